fetcher: RTL and testbench

FETCHER -- requirements
Module: fetcher

---
 rtl/fetcher_pkg.sv | 25 ++
 rtl/fetcher_if.sv | 27 ++
 rtl/fetcher_branch_predict_decode.sv | 47 ++++
 rtl/fetcher.sv | 99 +++++++++
 tb/tb_fetcher.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetcher_pkg.sv
// Shared constants and types for the instruction fetcher: datapath sizing,
// RV32/RV32C control-flow opcodes and the control-flow class used by the predictor.
package fetcher_pkg;

  localparam int XLEN     = 32;
  localparam int BHT_SIZE = 64;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] RVC_Q1       = 2'b01;
  localparam logic [2:0] RVC_F3_JAL   = 3'b001;
  localparam logic [2:0] RVC_F3_J     = 3'b101;
  localparam logic [2:0] RVC_F3_BEQZ  = 3'b110;
  localparam logic [2:0] RVC_F3_BNEZ  = 3'b111;

  localparam logic [1:0] BHT_INIT = 2'b01;

  typedef enum logic [1:0] {
    CLS_SEQ,
    CLS_JUMP,
    CLS_BRANCH
  } ctrl_cls_e;

endpackage

// File: rtl/fetcher_if.sv
// Fetch-side bundle: icache request/response plus the instruction handed to the queue.
interface fetcher_if #(
  parameter int XLEN = fetcher_pkg::XLEN
);
  logic            fet_icache_enable;
  logic [XLEN-1:0] fet_pc;
  logic            icache_ready;
  logic [XLEN-1:0] icache_inst;
  logic            iq_full;
  logic            fet_inst_ready;
  logic [XLEN-1:0] fet_inst;
  logic [XLEN-1:0] fet_inst_addr;
  logic            fet_pred_jump;
  logic [XLEN-1:0] fet_pred_pc;

  modport master (
    output fet_icache_enable, fet_pc, fet_inst_ready, fet_inst,
           fet_inst_addr, fet_pred_jump, fet_pred_pc,
    input  icache_ready, icache_inst, iq_full
  );

  modport slave (
    input  fet_icache_enable, fet_pc, fet_inst_ready, fet_inst,
           fet_inst_addr, fet_pred_jump, fet_pred_pc,
    output icache_ready, icache_inst, iq_full
  );
endinterface

// File: rtl/fetcher_branch_predict_decode.sv
// Combinational immediate extraction and next-PC selection for one fetched instruction.
module branch_predict_decode
  import fetcher_pkg::*;
#(
  parameter int XLEN = fetcher_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] inst,
  input  logic            bht_taken,
  output logic            pred_jump,
  output logic [XLEN-1:0] pred_pc
);

  ctrl_cls_e       cls;
  logic [XLEN-1:0] imm;
  logic            is_rvc;

  assign is_rvc = (inst[1:0] != 2'b11);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cls = CLS_SEQ;
    imm = '0;
    if (!is_rvc) begin
      if (inst[6:0] == OPC_JAL) begin
        cls = CLS_JUMP;
        imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end else if (inst[6:0] == OPC_BRANCH) begin
        cls = CLS_BRANCH;
        imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
    end else if (inst[1:0] == RVC_Q1) begin
      if (inst[15:13] == RVC_F3_J || inst[15:13] == RVC_F3_JAL) begin
        cls = CLS_JUMP;
        imm = {{(XLEN-12){inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
               inst[2], inst[11], inst[5:3], 1'b0};
      end else if (inst[15:13] == RVC_F3_BEQZ || inst[15:13] == RVC_F3_BNEZ) begin
        cls = CLS_BRANCH;
        imm = {{(XLEN-9){inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};
      end
    end
  end

  assign pred_jump = (cls == CLS_JUMP) || (cls == CLS_BRANCH && bht_taken);
  assign pred_pc   = pred_jump ? pc + imm : pc + (is_rvc ? XLEN'(2) : XLEN'(4));

endmodule

// File: rtl/fetcher.sv
// Single-issue instruction fetcher with a 2-bit-counter branch history table
// predicting direct jumps and conditional branches.
module fetcher
  import fetcher_pkg::*;
#(
  parameter int          XLEN     = fetcher_pkg::XLEN,
  parameter int          BHT_SIZE = fetcher_pkg::BHT_SIZE,
  parameter logic [31:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            stall,
  input  logic            bu_update_enable,
  input  logic [XLEN-1:0] bu_update_pc,
  input  logic            bu_taken,
  fetcher_if.master       bus
);

  localparam int IDX_W = $clog2(BHT_SIZE);

  logic [XLEN-1:0]  pc_q;
  logic             ready_q;
  logic [XLEN-1:0]  inst_q;
  logic [XLEN-1:0]  addr_q;
  logic             pj_q;
  logic [XLEN-1:0]  ppc_q;
  logic [1:0]       bht [BHT_SIZE];

  logic [IDX_W-1:0] look_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             pred_jump;
  logic [XLEN-1:0]  pred_pc;
  logic             accept;
  logic             unused_pc_bits;

  assign look_idx = pc_q[IDX_W:1];
  assign upd_idx  = bu_update_pc[IDX_W:1];
  assign unused_pc_bits = ^{bu_update_pc[XLEN-1:IDX_W+1], bu_update_pc[0],
                            pc_q[0]};

  assign bus.fet_icache_enable = !rst && !flush && !stall && !bus.iq_full;
  assign accept                = bus.fet_icache_enable && bus.icache_ready;

  branch_predict_decode #(.XLEN(XLEN)) u_decode (
    .pc        (pc_q),
    .inst      (bus.icache_inst),
    .bht_taken (bht[look_idx][1]),
    .pred_jump (pred_jump),
    .pred_pc   (pred_pc)
  );

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= XLEN'(RESET_PC);
      ready_q <= 1'b0;
      inst_q  <= '0;
      addr_q  <= '0;
      pj_q    <= 1'b0;
      ppc_q   <= '0;
      // NOTE: the BHT is a register array, not SRAM, so it is reset entry by entry.
      for (int i = 0; i < BHT_SIZE; i++) bht[i] <= BHT_INIT;
    end else begin
      // Training is independent of flush/stall; lookup above reads the pre-update value.
      if (bu_update_enable) begin
        if (bu_taken && bht[upd_idx] != 2'b11)
          bht[upd_idx] <= bht[upd_idx] + 2'd1;
        else if (!bu_taken && bht[upd_idx] != 2'b00)
          bht[upd_idx] <= bht[upd_idx] - 2'd1;
      end

      if (flush) begin
        pc_q    <= flush_pc;
        ready_q <= 1'b0;
      end else if (stall) begin
        pc_q    <= pc_q;
      end else if (accept) begin
        pc_q    <= pred_pc;
        ready_q <= 1'b1;
        inst_q  <= bus.icache_inst;
        addr_q  <= pc_q;
        pj_q    <= pred_jump;
        ppc_q   <= pred_pc;
      end else begin
        ready_q <= 1'b0;
      end
    end
  end

  assign bus.fet_pc         = pc_q;
  assign bus.fet_inst_ready = ready_q;
  assign bus.fet_inst       = inst_q;
  assign bus.fet_inst_addr  = addr_q;
  assign bus.fet_pred_jump  = pj_q;
  assign bus.fet_pred_pc    = ppc_q;

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: directed scenarios plus randomized traffic
// compared against a behavioural model derived from the RISC-V encodings.
module tb_fetcher;

  logic        clk = 1'b0;
  logic        rst, flush, stall, bu_update_enable, bu_taken;
  logic [31:0] flush_pc, bu_update_pc;

  int n_tests = 0;
  int n_fail  = 0;

  fetcher_if #(.XLEN(32)) bus ();

  fetcher #(.XLEN(32), .BHT_SIZE(64), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .flush_pc         (flush_pc),
    .stall            (stall),
    .bu_update_enable (bu_update_enable),
    .bu_update_pc     (bu_update_pc),
    .bu_taken         (bu_taken),
    .bus              (bus.master)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [31:0] m_pc, m_inst, m_addr, m_ppc;
  bit          m_ready, m_pj;
  int          m_bht [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bht_slot(input logic [31:0] pc);
    return int'((pc / 2) % 64);
  endfunction

  // Prediction straight from the ISA immediate layouts, using weighted bit sums.
  function automatic void predict(input logic [31:0] pc, input logic [31:0] inst,
                                  input int ctr, output bit jump, output logic [31:0] nxt);
    int  off;
    bit  is_jump, is_br;
    off = 0; is_jump = 0; is_br = 0;
    if (inst[1:0] == 2'b11) begin
      if (inst[6:0] == 7'h6F) begin
        is_jump = 1;
        off = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096
              - int'(inst[31]) * 1048576;
      end else if (inst[6:0] == 7'h63) begin
        is_br = 1;
        off = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32 + int'(inst[7]) * 2048
              - int'(inst[31]) * 4096;
      end
    end else if (inst[1:0] == 2'b01) begin
      if (inst[15:13] == 3'd5 || inst[15:13] == 3'd1) begin
        is_jump = 1;
        off = int'(inst[5:3]) * 2 + int'(inst[11]) * 16 + int'(inst[2]) * 32
              + int'(inst[7]) * 64 + int'(inst[6]) * 128 + int'(inst[10:9]) * 256
              + int'(inst[8]) * 1024 - int'(inst[12]) * 2048;
      end else if (inst[15:13] == 3'd6 || inst[15:13] == 3'd7) begin
        is_br = 1;
        off = int'(inst[4:3]) * 2 + int'(inst[11:10]) * 8 + int'(inst[2]) * 32
              + int'(inst[6:5]) * 64 - int'(inst[12]) * 256;
      end
    end
    jump = is_jump || (is_br && ctr >= 2);
    if (jump) nxt = pc + off;
    else      nxt = pc + ((inst[1:0] == 2'b11) ? 4 : 2);
  endfunction

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic step();
    bit          en, pj;
    logic [31:0] ppc;
    int          s;
    #1;
    en = !rst && !flush && !stall && !bus.iq_full;
    check("icache_enable", bus.fet_icache_enable, en);
    check("fet_pc_pre", bus.fet_pc, m_pc);
    if (rst) begin
      m_pc = 0; m_ready = 0; m_inst = 0; m_addr = 0; m_pj = 0; m_ppc = 0;
      foreach (m_bht[i]) m_bht[i] = 1;
    end else begin
      predict(m_pc, bus.icache_inst, m_bht[bht_slot(m_pc)], pj, ppc);
      if (bu_update_enable) begin
        s = bht_slot(bu_update_pc);
        m_bht[s] = bu_taken ? ((m_bht[s] < 3) ? m_bht[s] + 1 : 3)
                            : ((m_bht[s] > 0) ? m_bht[s] - 1 : 0);
      end
      if (flush) begin
        m_pc = flush_pc; m_ready = 0;
      end else if (!stall) begin
        if (en && bus.icache_ready) begin
          m_ready = 1; m_inst = bus.icache_inst; m_addr = m_pc;
          m_pj = pj; m_ppc = ppc; m_pc = ppc;
        end else begin
          m_ready = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    check("fet_pc", bus.fet_pc, m_pc);
    check("inst_ready", bus.fet_inst_ready, m_ready);
    check("fet_inst", bus.fet_inst, m_inst);
    check("inst_addr", bus.fet_inst_addr, m_addr);
    check("pred_jump", bus.fet_pred_jump, m_pj);
    check("pred_pc", bus.fet_pred_pc, m_ppc);
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 0; flush = 0; stall = 0; flush_pc = 0;
    bus.iq_full = 0; bus.icache_ready = 0; bus.icache_inst = 0;
    bu_update_enable = 0; bu_update_pc = 0; bu_taken = 0;
  endtask

  task automatic go_to(input logic [31:0] addr);
    set_idle(); flush = 1; flush_pc = addr; step(); flush = 0;
  endtask

  task automatic fetch(input logic [31:0] inst);
    set_idle(); bus.icache_ready = 1; bus.icache_inst = inst; step();
  endtask

  task automatic train(input logic [31:0] pc, input bit taken);
    set_idle(); bu_update_enable = 1; bu_update_pc = pc; bu_taken = taken; step();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0: r = $urandom | 32'h3;
      1: r = ($urandom & ~32'h7F) | 32'h6F;
      2: r = ($urandom & ~32'h7F) | 32'h63;
      3: r = ($urandom & ~32'h7F) | 32'h67;
      4: r = ($urandom & 32'hFFFC) | $urandom_range(0, 2);
      5: r = ($urandom & 32'h1FFC) | ($urandom_range(0, 1) ? 32'hA000 : 32'h2000) | 32'h1;
      6: r = ($urandom & 32'h1FFC) | ($urandom_range(0, 1) ? 32'hE000 : 32'hC000) | 32'h1;
      default: r = ($urandom & 32'hFFFC) | 32'h1;
    endcase
    return r;
  endfunction

  initial begin
    set_idle();
    rst = 1;
    m_pc = 0; m_ready = 0; m_inst = 0; m_addr = 0; m_pj = 0; m_ppc = 0;
    foreach (m_bht[i]) m_bht[i] = 1;
    @(negedge clk);
    step();
    step();
    check("rst_ready", bus.fet_inst_ready, 0);
    check("rst_pc", bus.fet_pc, 0);
    check("rst_inst", bus.fet_inst, 0);

    // Basic 32-bit sequential fetch.
    fetch(32'h0000_0013);
    check("nop_ready", bus.fet_inst_ready, 1);
    check("nop_addr", bus.fet_inst_addr, 0);
    check("nop_pc", bus.fet_pc, 32'h4);
    check("nop_pj", bus.fet_pred_jump, 0);

    // Stall freezes outputs including the valid pulse.
    set_idle(); stall = 1; bus.icache_ready = 1; bus.icache_inst = 32'h13; step();
    check("stall_ready", bus.fet_inst_ready, 1);
    check("stall_pc", bus.fet_pc, 32'h4);

    // Compressed sequential fetch.
    go_to(32'h10);
    fetch(32'h0000_4501);
    check("cli_pc", bus.fet_pc, 32'h12);
    check("cli_pj", bus.fet_pred_jump, 0);

    // JAL predicted taken.
    go_to(32'h20);
    fetch(32'h0080_006F);
    check("jal_pj", bus.fet_pred_jump, 1);
    check("jal_ppc", bus.fet_pred_pc, 32'h28);
    check("jal_pc", bus.fet_pc, 32'h28);

    // BHT training, saturation and same-cycle update/lookup.
    train(32'h40, 1);
    train(32'h40, 1);
    go_to(32'h40);
    fetch(32'hFE00_0CE3);
    check("beq_pj", bus.fet_pred_jump, 1);
    check("beq_pc", bus.fet_pc, 32'h38);
    train(32'h40, 1);
    train(32'h40, 1);
    train(32'h40, 0);
    go_to(32'h40);
    set_idle(); bus.icache_ready = 1; bus.icache_inst = 32'hFE00_0CE3;
    bu_update_enable = 1; bu_update_pc = 32'h40; bu_taken = 0; step();
    check("sat_pre_update_pj", bus.fet_pred_jump, 1);
    check("sat_pre_update_pc", bus.fet_pc, 32'h38);
    go_to(32'h40);
    fetch(32'hFE00_0CE3);
    check("beq_nt_pj", bus.fet_pred_jump, 0);
    check("beq_nt_pc", bus.fet_pc, 32'h44);

    // iq_full back-pressure with icache hitting.
    for (int i = 0; i < 3; i++) begin
      set_idle(); bus.iq_full = 1; bus.icache_ready = 1; bus.icache_inst = 32'h13; step();
      check("iqf_enable", bus.fet_icache_enable, 0);
      check("iqf_pc", bus.fet_pc, 32'h44);
      check("iqf_ready", bus.fet_inst_ready, 0);
    end

    // Flush beats stall and hit.
    set_idle(); flush = 1; flush_pc = 32'h100; stall = 1;
    bus.icache_ready = 1; bus.icache_inst = 32'h0080_006F; step();
    check("flush_pc", bus.fet_pc, 32'h100);
    check("flush_ready", bus.fet_inst_ready, 0);

    // Reset mid-stream discards the in-flight hit.
    fetch(32'h13);
    set_idle(); rst = 1; bus.icache_ready = 1; bus.icache_inst = 32'h13; step();
    check("midrst_ready", bus.fet_inst_ready, 0);
    check("midrst_pc", bus.fet_pc, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      rst              = ($urandom_range(0, 63) == 0);
      flush            = ($urandom_range(0, 15) == 0);
      flush_pc         = $urandom & 32'hFFFF_FFFE;
      stall            = ($urandom_range(0, 7) == 0);
      bus.iq_full      = ($urandom_range(0, 5) == 0);
      bus.icache_ready = ($urandom_range(0, 3) != 0);
      bus.icache_inst  = rand_inst();
      bu_update_enable = ($urandom_range(0, 2) == 0);
      bu_update_pc     = $urandom_range(0, 1) ? m_pc : $urandom;
      bu_taken         = $urandom_range(0, 1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
